imem_port_arbiter: RTL and testbench

Shares the single-port synchronous instruction memory between the RV32 core's fetch port and the JTAG/Avalon debug loader. Arbitrates one access per clock, steers read data back to the owner, and commits debug writes for program download. Debug has fixed priority with a starvation guard for fetch. Sits between the core and the IMEM RAM inside the system top.

---
 rtl/imem_port_arbiter.sv | 118 +++++++++++
 tb/tb_imem_port_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_port_arbiter.sv
// Single-port IMEM arbiter: debug loader has fixed priority over core fetch, with a starvation guard for fetch.
// Optional macro IMEM_ARB_WRLOCK_EN adds the wr_unlock write-protect input and the sticky wr_err flag.
module imem_port_arbiter #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_W_IMEM  = 12,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   f_req,
  input  logic [ADDR_W_IMEM-1:0] f_addr,
  output logic                   f_gnt,
  output logic                   f_rvalid,
  output logic [DATA_WIDTH-1:0]  f_rdata,
  input  logic                   d_read,
  input  logic                   d_write,
  input  logic [ADDR_W_IMEM-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0]  d_wdata,
  output logic                   d_waitrequest,
  output logic                   d_readdatavalid,
  output logic [DATA_WIDTH-1:0]  d_readdata,
  output logic [ADDR_W_IMEM-3:0] m_addr,
  output logic                   m_we,
  output logic [DATA_WIDTH-1:0]  m_wdata,
`ifdef IMEM_ARB_WRLOCK_EN
  input  logic                   wr_unlock,
  output logic                   wr_err,
`endif
  input  logic [DATA_WIDTH-1:0]  m_rdata
);

  localparam int unsigned WORD_W = ADDR_W_IMEM - 2;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_DEBUG} owner_e;

  owner_e              rd_owner, rd_owner_nxt;
  logic [CNT_W-1:0]    starve_cnt, starve_nxt;
  logic [WORD_W-1:0]   addr_q, addr_nxt;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_nxt;
  logic                d_req, d_gnt, starved, wr_ok;
  logic                unused_addr_lsbs;

  // Byte-offset bits are deliberately ignored; words are always aligned.
  assign unused_addr_lsbs = ^{f_addr[1:0], d_addr[1:0]};

`ifdef IMEM_ARB_WRLOCK_EN
  assign wr_ok = wr_unlock;
`else
  assign wr_ok = 1'b1;
`endif

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_owner   <= OWN_NONE;
      starve_cnt <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      rd_owner   <= rd_owner_nxt;
      starve_cnt <= starve_nxt;
      addr_q     <= addr_nxt;
      wdata_q    <= wdata_nxt;
    end
  end

  // Grant decision, memory steering and next-state
  always_comb begin
    rd_owner_nxt = OWN_NONE;
    starve_nxt   = starve_cnt;
    addr_nxt     = addr_q;
    wdata_nxt    = wdata_q;

    d_req   = d_read | d_write;
    starved = f_req && (starve_cnt == CNT_W'(STARVE_LIMIT));
    d_gnt   = !reset && d_req && !starved;
    f_gnt   = !reset && f_req && !d_gnt;

    if (f_gnt) begin
      addr_nxt     = f_addr[ADDR_W_IMEM-1:2];
      rd_owner_nxt = OWN_FETCH;
    end else if (d_gnt) begin
      addr_nxt = d_addr[ADDR_W_IMEM-1:2];
      if (d_read) rd_owner_nxt = OWN_DEBUG;
      if (d_write) wdata_nxt = d_wdata;
    end

    if (!f_req || f_gnt) begin
      starve_nxt = '0;
    end else if (starve_cnt < CNT_W'(STARVE_LIMIT)) begin
      starve_nxt = starve_cnt + CNT_W'(1);
    end

    d_waitrequest = !d_gnt;
    m_we          = d_gnt && d_write && wr_ok;
    m_addr        = addr_nxt;
    m_wdata       = wdata_nxt;
  end

  // Read return: RAM output is shared, the owner tag qualifies it; reset drops in-flight data.
  assign f_rdata         = m_rdata;
  assign d_readdata      = m_rdata;
  assign f_rvalid        = !reset && (rd_owner == OWN_FETCH);
  assign d_readdatavalid = !reset && (rd_owner == OWN_DEBUG);

`ifdef IMEM_ARB_WRLOCK_EN
  // Sticky flag for a debug write attempted while locked
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_err <= 1'b0;
    end else if (d_gnt && d_write && !wr_unlock) begin
      wr_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Scoreboard bench for imem_port_arbiter with a write-first 1-cycle RAM model.
// Also covers the write-lock option when IMEM_ARB_WRLOCK_EN is defined.
module tb_imem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        f_req;
  logic [11:0] f_addr;
  logic        f_gnt;
  logic        f_rvalid;
  logic [31:0] f_rdata;
  logic        d_read;
  logic        d_write;
  logic [11:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_waitrequest;
  logic        d_readdatavalid;
  logic [31:0] d_readdata;
  logic [9:0]  m_addr;
  logic        m_we;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
`ifdef IMEM_ARB_WRLOCK_EN
  logic        wr_unlock;
  logic        wr_err;
  logic        unlock;
`endif

  imem_port_arbiter #(.DATA_WIDTH(32), .ADDR_W_IMEM(12), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_waitrequest(d_waitrequest), .d_readdatavalid(d_readdatavalid), .d_readdata(d_readdata),
    .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata),
`ifdef IMEM_ARB_WRLOCK_EN
    .wr_unlock(wr_unlock), .wr_err(wr_err),
`endif
    .m_rdata(m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write-first synchronous RAM
  logic [31:0] ram [0:1023];
  initial for (int i = 0; i < 1024; i++) ram[i] = 32'hA500_0000 | 32'(i);
  always @(posedge clk) begin
    if (m_we) ram[m_addr] <= m_wdata;
    m_rdata <= m_we ? m_wdata : ram[m_addr];
  end

  typedef struct {
    logic [1:0]  owner;
    logic [31:0] data;
  } resp_t;

  resp_t       sb[$];
  logic [31:0] shadow [0:1023];
  logic [9:0]  exp_addr;
  logic [31:0] exp_wd;
  int          n_vec;
  int          n_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Compare this cycle's read-return against what the previous grant queued
  task automatic pop_resp();
    resp_t r;
    if (sb.size() > 0) r = sb.pop_front();
    else begin
      r.owner = 2'd0;
      r.data  = '0;
    end
    check("f_rvalid", 32'(f_rvalid), 32'(r.owner == 2'd1));
    check("d_readdatavalid", 32'(d_readdatavalid), 32'(r.owner == 2'd2));
    if (r.owner == 2'd1) check("f_rdata", f_rdata, r.data);
    if (r.owner == 2'd2) check("d_readdata", d_readdata, r.data);
  endtask

  task automatic cyc(input logic fr, input logic [11:0] fa, input logic dr, input logic dw,
                     input logic [11:0] da, input logic [31:0] wd, input logic eg_f, input logic eg_d);
    logic  we_e;
    resp_t r;
    f_req = fr; f_addr = fa; d_read = dr; d_write = dw; d_addr = da; d_wdata = wd;
`ifdef IMEM_ARB_WRLOCK_EN
    wr_unlock = unlock;
`endif
    @(negedge clk);
    pop_resp();
    we_e = eg_d && dw;
`ifdef IMEM_ARB_WRLOCK_EN
    we_e = we_e && unlock;
`endif
    if (eg_f) exp_addr = fa[11:2];
    else if (eg_d) exp_addr = da[11:2];
    if (eg_d && dw) exp_wd = wd;
    check("f_gnt", 32'(f_gnt), 32'(eg_f));
    check("d_waitrequest", 32'(d_waitrequest), 32'(!eg_d));
    check("m_we", 32'(m_we), 32'(we_e));
    check("m_addr", 32'(m_addr), 32'(exp_addr));
    check("m_wdata", m_wdata, exp_wd);
    if (eg_f) begin
      r.owner = 2'd1; r.data = shadow[fa[11:2]]; sb.push_back(r);
    end else if (eg_d && dr) begin
      r.owner = 2'd2; r.data = shadow[da[11:2]]; sb.push_back(r);
    end
    if (we_e) shadow[da[11:2]] = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 12'h0, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0);
  endtask

  // One reset cycle with requests pending: no grant, in-flight read dropped
  task automatic do_reset();
    reset = 1'b1; f_req = 1'b1; d_read = 1'b1; d_write = 1'b0;
    f_addr = 12'h018; d_addr = 12'h01C;
    @(negedge clk);
    check("rst f_gnt", 32'(f_gnt), 32'd0);
    check("rst d_waitrequest", 32'(d_waitrequest), 32'd1);
    check("rst m_we", 32'(m_we), 32'd0);
    check("rst f_rvalid", 32'(f_rvalid), 32'd0);
    check("rst d_readdatavalid", 32'(d_readdatavalid), 32'd0);
    sb.delete();
    exp_addr = '0;
    exp_wd   = '0;
    @(posedge clk);
    #1;
    reset = 1'b0; f_req = 1'b0; d_read = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    for (int i = 0; i < 1024; i++) shadow[i] = 32'hA500_0000 | 32'(i);
    reset = 1'b1; f_req = 1'b0; f_addr = '0; d_read = 1'b0; d_write = 1'b0;
    d_addr = '0; d_wdata = '0; exp_addr = '0; exp_wd = '0;
`ifdef IMEM_ARB_WRLOCK_EN
    unlock = 1'b1; wr_unlock = 1'b1;
`endif
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    idle();
`ifdef IMEM_ARB_WRLOCK_EN
    check("wr_err reset", 32'(wr_err), 32'd0);
`endif

    // Fetch stream, full throughput
    cyc(1'b1, 12'h000, 1'b0, 1'b0, 12'h0, 32'h0, 1'b1, 1'b0);
    cyc(1'b1, 12'h004, 1'b0, 1'b0, 12'h0, 32'h0, 1'b1, 1'b0);
    cyc(1'b1, 12'h008, 1'b0, 1'b0, 12'h0, 32'h0, 1'b1, 1'b0);
    idle();
    idle();

    // Debug write then read-back of the same word
    cyc(1'b0, 12'h0, 1'b0, 1'b1, 12'h010, 32'hDEADBEEF, 1'b0, 1'b1);
    cyc(1'b0, 12'h0, 1'b1, 1'b0, 12'h010, 32'h0, 1'b0, 1'b1);
    idle();

    // Unaligned fetch address
    cyc(1'b1, 12'h007, 1'b0, 1'b0, 12'h0, 32'h0, 1'b1, 1'b0);
    idle();

    // Debug saturates the port; fetch forced on the 5th cycle
    for (int k = 0; k < 4; k++)
      cyc(1'b1, 12'h020, 1'b1, 1'b0, 12'(12'h040 + 4 * k), 32'h0, 1'b0, 1'b1);
    cyc(1'b1, 12'h020, 1'b1, 1'b0, 12'h050, 32'h0, 1'b1, 1'b0);
    cyc(1'b0, 12'h0, 1'b1, 1'b0, 12'h050, 32'h0, 1'b0, 1'b1);
    cyc(1'b0, 12'h0, 1'b1, 1'b0, 12'h054, 32'h0, 1'b0, 1'b1);
    idle();

    // Debug write beats a fetch, then fetch reads the new word
    cyc(1'b1, 12'h014, 1'b0, 1'b1, 12'h014, 32'h0BADF00D, 1'b0, 1'b1);
    cyc(1'b1, 12'h014, 1'b0, 1'b0, 12'h0, 32'h0, 1'b1, 1'b0);
    idle();

    // Reset right after a fetch grant
    cyc(1'b1, 12'h00C, 1'b0, 1'b0, 12'h0, 32'h0, 1'b1, 1'b0);
    do_reset();
    idle();
    cyc(1'b1, 12'h00C, 1'b0, 1'b0, 12'h0, 32'h0, 1'b1, 1'b0);
    idle();

`ifdef IMEM_ARB_WRLOCK_EN
    // Locked write is accepted but not committed
    unlock = 1'b0;
    cyc(1'b0, 12'h0, 1'b0, 1'b1, 12'h000, 32'h12345678, 1'b0, 1'b1);
    check("wr_err set", 32'(wr_err), 32'd1);
    unlock = 1'b1;
    cyc(1'b0, 12'h0, 1'b1, 1'b0, 12'h000, 32'h0, 1'b0, 1'b1);
    idle();
    check("wr_err sticky", 32'(wr_err), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
